// File: rtl/words2_display_if.sv
`default_nettype none
// ============================================================================
// Module      : words2_display_if
// Description : Status-word select and seven-segment / anode drive bundle
//               between a game controller and the words2_display driver.
// Revision    : 1.0  initial release
// ============================================================================
interface words2_display_if;
  logic [2:0] wordSelect;  // word to display (0-7)
  logic [7:0] seg;         // active-low segments, seg[7] = dp
  logic [3:0] an;          // active-low anodes, an[3] = leftmost digit

  // Controller side: picks the word, observes the drive.
  modport master (
    output wordSelect,
    input  seg,
    input  an
  );

  // Display driver side.
  modport slave (
    input  wordSelect,
    output seg,
    output an
  );
endinterface
`default_nettype wire

// File: rtl/words2_display.sv
`default_nettype none
// ============================================================================
// Module      : words2_display
// Description : Four-digit common-anode seven-segment driver that shows one of
//               eight fixed 4-character game-status words, scanning one digit
//               every 2^REFRESH_BITS clocks.
// Revision    : 1.0  initial release
// ============================================================================
module words2_display #(
  parameter int REFRESH_BITS = 17
) (
  input  wire              clk,
  input  wire              clr,
  words2_display_if.slave  bus
);

  // Character codes used by the word ROM; 16 distinct glyphs fill 4 bits.
  localparam logic [3:0] CH_BLANK = 4'd0;
  localparam logic [3:0] CH_S     = 4'd1;
  localparam logic [3:0] CH_E     = 4'd2;
  localparam logic [3:0] CH_T     = 4'd3;   // lowercase t
  localparam logic [3:0] CH_F     = 4'd4;
  localparam logic [3:0] CH_I     = 4'd5;
  localparam logic [3:0] CH_R     = 4'd6;   // lowercase r
  localparam logic [3:0] CH_H     = 4'd7;
  localparam logic [3:0] CH_L     = 4'd8;
  localparam logic [3:0] CH_UO    = 4'd9;   // uppercase O
  localparam logic [3:0] CH_G     = 4'd10;
  localparam logic [3:0] CH_LO    = 4'd11;  // lowercase o
  localparam logic [3:0] CH_D     = 4'd12;  // lowercase d
  localparam logic [3:0] CH_P     = 4'd13;
  localparam logic [3:0] CH_A     = 4'd14;
  localparam logic [3:0] CH_DASH  = 4'd15;

  logic [REFRESH_BITS-1:0] prescaler_q, prescaler_d;
  logic [1:0]              idx_q, idx_d;
  logic [15:0]             w_word;    // {pos3 (leftmost), pos2, pos1, pos0}
  logic [3:0]              w_char;
  logic [6:0]              w_lit;     // lit segments, bit0 = a ... bit6 = g

  // Prescaler free-runs; the digit index steps when the prescaler wraps.
  always_comb begin
    prescaler_d = prescaler_q + {{(REFRESH_BITS-1){1'b0}}, 1'b1};
    idx_d       = idx_q;
    if (&prescaler_q) begin
      idx_d = idx_q + 2'd1;
    end
  end

  // Scan state register; clear wins over counting.
  always_ff @(posedge clk) begin
    if (clr) begin
      prescaler_q <= '0;
      idx_q       <= 2'd0;
    end else begin
      prescaler_q <= prescaler_d;
      idx_q       <= idx_d;
    end
  end

  // Word ROM: four character codes per word, leftmost in the top nibble.
  always_comb begin
    w_word = {CH_BLANK, CH_BLANK, CH_BLANK, CH_BLANK};
    case (bus.wordSelect)
      3'd0: w_word = {CH_BLANK, CH_BLANK, CH_BLANK, CH_BLANK};
      3'd1: w_word = {CH_S,     CH_E,     CH_T,     CH_BLANK};
      3'd2: w_word = {CH_F,     CH_I,     CH_R,     CH_E    };
      3'd3: w_word = {CH_H,     CH_I,     CH_T,     CH_BLANK};
      3'd4: w_word = {CH_L,     CH_UO,    CH_S,     CH_E    };
      3'd5: w_word = {CH_G,     CH_LO,    CH_LO,    CH_D    };
      3'd6: w_word = {CH_P,     CH_A,     CH_S,     CH_S    };
      3'd7: w_word = {CH_DASH,  CH_DASH,  CH_DASH,  CH_DASH };
      default: w_word = {CH_BLANK, CH_BLANK, CH_BLANK, CH_BLANK};
    endcase
  end

  // Character at the scanned position; position 0 is the rightmost digit.
  assign w_char = w_word[{idx_q, 2'b00} +: 4];

  // Glyph decoder: character code to lit segments (gfedcba).
  always_comb begin
    w_lit = 7'b0000000;
    case (w_char)
      CH_BLANK: w_lit = 7'b0000000;
      CH_S:     w_lit = 7'b1101101;  // a c d f g
      CH_E:     w_lit = 7'b1111001;  // a d e f g
      CH_T:     w_lit = 7'b1111000;  // d e f g
      CH_F:     w_lit = 7'b1110001;  // a e f g
      CH_I:     w_lit = 7'b0110000;  // e f
      CH_R:     w_lit = 7'b1010000;  // e g
      CH_H:     w_lit = 7'b1110110;  // b c e f g
      CH_L:     w_lit = 7'b0111000;  // d e f
      CH_UO:    w_lit = 7'b0111111;  // a b c d e f
      CH_G:     w_lit = 7'b0111101;  // a c d e f
      CH_LO:    w_lit = 7'b1011100;  // c d e g
      CH_D:     w_lit = 7'b1011110;  // b c d e g
      CH_P:     w_lit = 7'b1110011;  // a b e f g
      CH_A:     w_lit = 7'b1110111;  // a b c e f g
      CH_DASH:  w_lit = 7'b1000000;  // g
      default:  w_lit = 7'b0000000;
    endcase
  end

  // Active-low drive: decimal point always dark, one anode per index.
  assign bus.seg = {1'b1, ~w_lit};
  assign bus.an  = ~(4'b0001 << idx_q);

endmodule
`default_nettype wire

// File: tb/tb_words2_display.sv
`default_nettype none
// ============================================================================
// Module      : tb_words2_display
// Description : Self-checking bench for words2_display with a word/glyph
//               table model and directed scan, switch and reset vectors.
// Revision    : 1.0  initial release
// ============================================================================
module tb_words2_display;

  localparam int RB = 2;

  logic clk = 1'b0;
  logic clr = 1'b0;
  words2_display_if bus ();

  words2_display #(.REFRESH_BITS(RB)) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miss    = 0;

  // Model: clocks elapsed since the last clear edge.
  int m_cnt   = 0;
  bit m_valid = 1'b0;

  string words [8] = '{"____", "SEt_", "FIrE", "HIt_", "LOSE", "Good", "PASS", "----"};

  function automatic logic [7:0] glyph(input byte ch);
    case (ch)
      "_": return 8'hFF;
      "S": return 8'h92;
      "E": return 8'h86;
      "t": return 8'h87;
      "F": return 8'h8E;
      "I": return 8'hCF;
      "r": return 8'hAF;
      "H": return 8'h89;
      "L": return 8'hC7;
      "O": return 8'hC0;
      "G": return 8'hC2;
      "o": return 8'hA3;
      "d": return 8'hA1;
      "P": return 8'h8C;
      "A": return 8'h88;
      "-": return 8'hBF;
      default: return 8'h00;
    endcase
  endfunction

  function automatic int m_idx();
    return (m_cnt / (1 << RB)) % 4;
  endfunction

  function automatic logic [3:0] exp_an(input int idx);
    case (idx)
      0: return 4'b1110;
      1: return 4'b1101;
      2: return 4'b1011;
      default: return 4'b0111;
    endcase
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    vectors++;
    if (act !== exp) begin
      miss++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    if (clr) begin
      m_cnt   <= 0;
      m_valid <= 1'b1;
    end else begin
      m_cnt <= m_cnt + 1;
    end
  end

  // Compare DUT against the model every cycle once a clear has been seen.
  always @(negedge clk) begin
    if (m_valid) begin
      string w;
      int    idx;
      w   = words[bus.wordSelect];
      idx = m_idx();
      check("model_an",  {4'b0, bus.an}, {4'b0, exp_an(idx)});
      check("model_seg", bus.seg, glyph(w[3 - idx]));
      check("onehot_an", 8'($countones(~bus.an)), 8'd1);
    end
  end

  // Advance to the first cycle of digit idx (at posedge + 1).
  task automatic sync_to(input int idx);
    for (int i = 0; i < 64; i++) begin
      @(posedge clk);
      #1;
      if (m_idx() == idx && (m_cnt % (1 << RB)) == 0) return;
    end
    vectors++;
    miss++;
    $display("FAIL sync_to: index %0d not reached within 64 cycles", idx);
  endtask

  task automatic lit(input string name, input logic [3:0] an_e, input logic [7:0] seg_e);
    check({name, "_an"}, {4'b0, bus.an}, {4'b0, an_e});
    check({name, "_seg"}, bus.seg, seg_e);
  endtask

  initial begin
    bus.wordSelect = 3'd1;
    clr = 1'b1;
    repeat (2) @(posedge clk);
    #1 clr = 1'b0;

    // Reset and first scan of "SEt_".
    @(negedge clk);
    lit("rst", 4'b1110, 8'hFF);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_hold_an", {4'b0, bus.an}, 8'h0E);
    end
    sync_to(1); @(negedge clk); lit("scan1_t", 4'b1101, 8'h87);
    sync_to(2); @(negedge clk); lit("scan1_E", 4'b1011, 8'h86);
    sync_to(3); @(negedge clk); lit("scan1_S", 4'b0111, 8'h92);
    sync_to(0); @(negedge clk); lit("scan1_wrap", 4'b1110, 8'hFF);

    // "FIrE" held for a full scan.
    bus.wordSelect = 3'd2;
    sync_to(0); @(negedge clk); lit("fire0", 4'b1110, 8'h86);
    sync_to(1); @(negedge clk); lit("fire1", 4'b1101, 8'hAF);
    sync_to(2); @(negedge clk); lit("fire2", 4'b1011, 8'hCF);
    sync_to(3); @(negedge clk); lit("fire3", 4'b0111, 8'h8E);

    // Switch 3 -> 5 in the middle of digit 2.
    bus.wordSelect = 3'd3;
    sync_to(2); @(negedge clk); lit("sw_I", 4'b1011, 8'hCF);
    #1 bus.wordSelect = 3'd5;
    #1 lit("sw_o", 4'b1011, 8'hA3);

    // Clear while digit 3 is showing.
    sync_to(3);
    clr = 1'b1;
    @(posedge clk);
    #1 clr = 1'b0;
    @(negedge clk); lit("clr_d", 4'b1110, 8'hA1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("clr_hold_an", {4'b0, bus.an}, 8'h0E);
    end
    @(negedge clk); lit("clr_next_o", 4'b1101, 8'hA3);

    // Sweep every word over a full scan; the compare process checks all.
    for (int ws = 0; ws < 8; ws++) begin
      sync_to(0);
      bus.wordSelect = 3'(ws);
      repeat (4 * (1 << RB)) @(negedge clk);
    end
    check("dash_seg", bus.seg, 8'hBF);

    @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miss);
    $finish;
  end

endmodule
`default_nettype wire
